// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one 3-input logic-op evaluator across NUM_REQ requesters.
// Optional power-on sweep engine enabled by defining LOGIC_OP_ARB_SWEEP_EN.
module logic_op_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [3*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [2:0]           rsp_in,
    output logic                 rsp_out,
    output logic                 rsp_parity,
    output logic                 rsp_any,
    output logic [15:0]          grant_cnt
`ifdef LOGIC_OP_ARB_SWEEP_EN
    ,
    input  logic                 sweep_start,
    output logic                 sweep_done,
    output logic                 sweep_err
`endif
);

    // Shared evaluator: {out, parity, any}; out is 1 when at most one input bit is set.
    function automatic logic [2:0] my_logic_op(input logic [2:0] code);
        logic at_most_one;
        at_most_one = ~((code[0] & code[1]) | (code[0] & code[2]) | (code[1] & code[2]));
        return {at_most_one, ^code, |code};
    endfunction

    logic [ID_W-1:0] ptr_r;
    logic [NUM_REQ-1:0] grant_s;
    logic [ID_W-1:0] gid_s;
    logic [2:0] code_s;
    logic [2:0] eval_in_s;
    logic [2:0] eval_s;
    logic out_free_s;
    logic grant_en_s;
    logic accept_s;
    logic sweep_active_s;

    logic rsp_valid_r;
    logic [ID_W-1:0] rsp_id_r;
    logic [2:0] rsp_in_r;
    logic rsp_out_r;
    logic rsp_parity_r;
    logic rsp_any_r;
    logic [15:0] grant_cnt_r;

    assign out_free_s = ~rsp_valid_r | rsp_ready;
    assign grant_en_s = out_free_s & ~sweep_active_s;
    assign accept_s   = |grant_s;
    assign eval_s     = my_logic_op(eval_in_s);

    // Round-robin search from ptr_r upward, first valid requester wins.
    always_comb begin
        int idx;
        logic found;
        grant_s = {NUM_REQ{1'b0}};
        gid_s   = {ID_W{1'b0}};
        found   = 1'b0;
        idx     = 32'sd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_r) + k;
            idx = idx - ((idx >= NUM_REQ) ? NUM_REQ : 32'sd0);
            if (grant_en_s && !found && req_valid[ID_W'(idx)]) begin
                grant_s[ID_W'(idx)] = 1'b1;
                gid_s               = ID_W'(idx);
                found               = 1'b1;
            end else begin
                found = found;
            end
        end
    end

    // Code of the granted requester.
    always_comb begin
        code_s = 3'b000;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gid_s == ID_W'(i)) begin
                code_s = req_data[3*i +: 3];
            end else begin
                code_s = code_s;
            end
        end
    end

`ifdef LOGIC_OP_ARB_SWEEP_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } sweep_state_t;

    localparam logic [7:0] GOLD_OUT = 8'b0001_0111;
    localparam logic [7:0] GOLD_PAR = 8'b1001_0110;

    sweep_state_t state_r, state_s;
    logic [2:0] sweep_cnt_r;
    logic sweep_done_r;
    logic sweep_err_r;

    assign sweep_active_s = (state_r == ST_SWEEP);
    assign eval_in_s      = sweep_active_s ? sweep_cnt_r : code_s;
    assign sweep_done     = sweep_done_r;
    assign sweep_err      = sweep_err_r;

    // Sweep next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (sweep_start) state_s = ST_SWEEP;
                else             state_s = ST_IDLE;
            end
            ST_SWEEP: begin
                if (sweep_cnt_r == 3'd7) state_s = ST_DONE;
                else                     state_s = ST_SWEEP;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Sweep state, code counter and golden-table comparison.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            sweep_cnt_r  <= 3'd0;
            sweep_done_r <= 1'b0;
            sweep_err_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            sweep_cnt_r  <= sweep_active_s ? sweep_cnt_r + 3'd1 : 3'd0;
            sweep_done_r <= sweep_active_s && (sweep_cnt_r == 3'd7);
            if (state_r == ST_IDLE && sweep_start) begin
                sweep_err_r <= 1'b0;
            end else if (sweep_active_s &&
                         ((eval_s[2] != GOLD_OUT[sweep_cnt_r]) ||
                          (eval_s[1] != GOLD_PAR[sweep_cnt_r]))) begin
                sweep_err_r <= 1'b1;
            end
        end
    end
`else
    assign sweep_active_s = 1'b0;
    assign eval_in_s      = code_s;
`endif

    // Response register, round-robin pointer and saturating grant counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= {ID_W{1'b0}};
            rsp_in_r     <= 3'b000;
            rsp_out_r    <= 1'b1;
            rsp_parity_r <= 1'b0;
            rsp_any_r    <= 1'b0;
            grant_cnt_r  <= 16'h0000;
            ptr_r        <= {ID_W{1'b0}};
        end else if (accept_s) begin
            rsp_valid_r  <= 1'b1;
            rsp_id_r     <= gid_s;
            rsp_in_r     <= code_s;
            rsp_out_r    <= eval_s[2];
            rsp_parity_r <= eval_s[1];
            rsp_any_r    <= eval_s[0];
            grant_cnt_r  <= (grant_cnt_r == 16'hFFFF) ? grant_cnt_r : grant_cnt_r + 16'h0001;
            ptr_r        <= (gid_s == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : gid_s + 1'b1;
        end else if (rsp_ready) begin
            rsp_valid_r  <= 1'b0;
        end
    end

    assign req_ready  = grant_s;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_in     = rsp_in_r;
    assign rsp_out    = rsp_out_r;
    assign rsp_parity = rsp_parity_r;
    assign rsp_any    = rsp_any_r;
    assign grant_cnt  = grant_cnt_r;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Scoreboard bench for logic_op_arbiter (default build, NUM_REQ=4).
module tb_logic_op_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [11:0] req_data;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [2:0]  rsp_in;
    logic        rsp_out;
    logic        rsp_parity;
    logic        rsp_any;
    logic [15:0] grant_cnt;

    logic_op_arbiter #(.NUM_REQ(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_in(rsp_in), .rsp_out(rsp_out), .rsp_parity(rsp_parity),
        .rsp_any(rsp_any), .grant_cnt(grant_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] id;
        logic [2:0] code;
        logic       out;
        logic       par;
        logic       any;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;
    int m_ptr = 0;
    bit m_valid = 1'b0;
    int m_cnt = 0;
    int last_w = -1;

    bit out_seq[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    bit par_seq[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference round-robin: first valid requester at or after p, wrapping.
    function automatic int pick(input logic [3:0] v, input int p);
        int idx;
        for (int k = 0; k < 4; k++) begin
            idx = (p + k) % 4;
            if (v[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 4'b0000;
        req_data = 12'h000;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_valid = 1'b0;
        m_ptr = 0;
        m_cnt = 0;
    endtask

    // One cycle of stimulus; the model predicts the grant and pushes the expected response.
    task automatic step(input logic [3:0] v, input logic [11:0] d, input logic rr);
        int w;
        logic [3:0] exp_g;
        logic [2:0] c;
        exp_t e;
        req_valid = v;
        req_data = d;
        rsp_ready = rr;
        #1;
        w = (!m_valid || rr) ? pick(v, m_ptr) : -1;
        exp_g = 4'b0000;
        if (w >= 0) exp_g[w[1:0]] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_g));
        last_w = w;
        if (w >= 0) begin
            c = 3'(d >> (3 * w));
            e.id = w[1:0];
            e.code = c;
            e.out = ($countones(c) <= 1);
            e.par = ^c;
            e.any = (c != 3'b000);
            q.push_back(e);
            m_ptr = (w + 1) % 4;
            if (m_cnt < 65535) m_cnt++;
            m_valid = 1'b1;
        end else if (rr) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        chk("grant_cnt", 32'(grant_cnt), 32'(m_cnt));
    endtask

    // Monitor: compare the presented response with the scoreboard head; pop on consume.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got id %0d code %0d expected no response", rsp_id, rsp_in);
                end else begin
                    chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
                    chk("rsp_in", 32'(rsp_in), 32'(q[0].code));
                    chk("rsp_out", 32'(rsp_out), 32'(q[0].out));
                    chk("rsp_parity", 32'(rsp_parity), 32'(q[0].par));
                    chk("rsp_any", 32'(rsp_any), 32'(q[0].any));
                    if (rsp_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [1:0] held_id;
        logic [2:0] held_in;
        rst = 1'b1;
        req_valid = 4'b0000;
        req_data = 12'h000;
        rsp_ready = 1'b0;
        do_reset();

        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_rsp_in", 32'(rsp_in), 32'd0);
        chk("reset_rsp_out", 32'(rsp_out), 32'd1);
        chk("reset_rsp_parity", 32'(rsp_parity), 32'd0);
        chk("reset_rsp_any", 32'(rsp_any), 32'd0);
        chk("reset_grant_cnt", 32'(grant_cnt), 32'd0);

        step(4'b0001, 12'h003, 1'b1);
        chk("first_out", 32'(rsp_out), 32'd0);
        chk("first_parity", 32'(rsp_parity), 32'd0);
        chk("first_any", 32'(rsp_any), 32'd1);
        chk("first_id", 32'(rsp_id), 32'd0);
        chk("first_cnt", 32'(grant_cnt), 32'd1);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 12'($urandom), 1'b1);
            chk("rotate_grant", 32'(last_w), 32'(i % 4));
            chk("rotate_rsp_id", 32'(rsp_id), 32'(i % 4));
        end

        held_id = rsp_id;
        held_in = rsp_in;
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 12'($urandom), 1'b0);
            chk("hold_id", 32'(rsp_id), 32'(held_id));
            chk("hold_in", 32'(rsp_in), 32'(held_in));
        end
        step(4'b1111, 12'($urandom), 1'b1);
        chk("resume_grant", 32'(last_w), 32'd1);

        for (int c = 0; c < 8; c++) begin
            step(4'b0100, 12'(c) << 6, 1'b1);
            chk("seq_id", 32'(rsp_id), 32'd2);
            chk("seq_out", 32'(rsp_out), 32'(out_seq[c]));
            chk("seq_parity", 32'(rsp_parity), 32'(par_seq[c]));
        end

        step(4'b1111, 12'($urandom), 1'b0);
        chk("pre_reset_valid", 32'(rsp_valid), 32'd1);
        do_reset();
        chk("midreset_valid", 32'(rsp_valid), 32'd0);
        chk("midreset_cnt", 32'(grant_cnt), 32'd0);
        step(4'b1111, 12'($urandom), 1'b1);
        chk("post_reset_winner", 32'(rsp_id), 32'd0);

        repeat (300) begin
            step(4'($urandom), 12'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/logic_op_arbiter.md
# logic_op_arbiter

Round-robin arbiter and response pipeline that shares one `my_logic_op` 3-input evaluator between `NUM_REQ` requesters. It accepts at most one 3-bit code per cycle and evaluates it through the shared evaluator. It returns a registered response tagged with the requester id, under valid/ready backpressure. An optional built-in sweep engine exercises all eight codes against a golden table for power-on self-test.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `ID_W`: derived localparam, `$clog2(NUM_REQ)`; not user-set.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  request valid, one bit per requester.
- `req_data`  in  3*NUM_REQ  requester i's code is `req_data[3i+2:3i]`.
- `req_ready`  out  NUM_REQ  one-hot grant; all-zero when nothing is granted.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  ID_W  index of the granted requester.
- `rsp_in`  out  3  echo of the evaluated code.
- `rsp_out`  out  1  evaluator `out`: 1 when `$countones(code) <= 1`.
- `rsp_parity`  out  1  `^code`.
- `rsp_any`  out  1  `|code`.
- `grant_cnt`  out  16  saturating count of accepted requests.
- `sweep_start`, `sweep_done`, `sweep_err`: present only with the macro (see Configuration).

## Operation
- Output stage is free when `!rsp_valid || rsp_ready`.
- Grant rules:
  - A grant is issued only when the output stage is free and no sweep is active.
  - Round-robin search starts at pointer `ptr` and goes upward, wrapping modulo `NUM_REQ`.
  - The first requester with `req_valid=1` gets `req_ready=1`.
  - `req_ready` is combinational from `req_valid`, `ptr`, the output-stage state and the sweep state.
  - `req_ready[i]` never asserts when `req_valid[i]=0`.
- Accept happens on `req_valid[i] & req_ready[i]`. On accept:
  - The code drives the shared evaluator.
  - `rsp_*` fields are registered.
  - `ptr` becomes `(i+1) mod NUM_REQ`.
  - `grant_cnt` increments, saturating at `0xFFFF`.
- `ptr` is unchanged on any cycle with no grant.
- While `rsp_valid=1` and `rsp_ready=0`, every `rsp_*` output holds stable.
- `rsp_valid` deasserts after a consuming `rsp_ready` unless a new accept happens in the same cycle.
- Reset values:
  - `rsp_valid=0`, `rsp_id=0`, `rsp_in=0`.
  - `rsp_out=1`, `rsp_parity=0`, `rsp_any=0` (the evaluation of code 0).
  - `grant_cnt=0`, `ptr=0`.
  - Sweep outputs 0; sweep FSM in IDLE.
- `rst` asserted mid-transfer drops any held response. It is not replayed.

## Timing
- Latency: an accept in cycle N gives `rsp_valid=1` in cycle N+1 with that request's fields.
- Throughput: 1 response per cycle when `rsp_ready` is held high.
- Simultaneous consume and accept (`rsp_valid & rsp_ready` together with a new grant) replaces the register contents in one cycle, with no bubble.
- Simultaneous requests: exactly one grant per cycle.
- Fairness: a continuously requesting requester waits at most `NUM_REQ-1` grants.
- `req_ready` settles within the same cycle; requesters must not make `req_valid` depend on `req_ready`.

## Configuration
- `LOGIC_OP_ARB_SWEEP_EN` defined adds the sweep engine and its ports:
  - `sweep_start`  in  1.
  - `sweep_done`  out  1  one-cycle pulse.
  - `sweep_err`  out  1  sticky.
- Sweep FSM states and transitions:
  - IDLE: `sweep_start=1` in cycle N moves to SWEEP at N+1 and clears `sweep_err`. Grants in cycle N proceed normally.
  - SWEEP: 8 cycles, codes 0..7 in order into the evaluator. `req_ready` is all-zero.
  - Each sweep cycle compares evaluator `out` against golden `8'b0001_0111` and parity against `8'b1001_0110`, indexed by code. Any mismatch sets `sweep_err`.
  - DONE: 1 cycle; `sweep_done=1`; returns to IDLE.
- `sweep_start` is ignored outside IDLE.
- The sweep never writes the response register. A held `rsp_*` stays stable through the sweep.
- Macro undefined: the sweep ports are absent and grants are never blocked by a sweep.

## Test plan
- Reset, then `req_valid=4'b0001` and `req_data[2:0]=3'b011` with `rsp_ready=1`. The next cycle gives `rsp_valid=1`, `rsp_id=0`, `rsp_out=0`, `rsp_parity=0`, `rsp_any=1`, `grant_cnt=1`.
- All 4 requesters valid continuously with `rsp_ready=1`. Grants rotate 0,1,2,3,0. `rsp_id` follows at 1-cycle lag with no bubbles.
- `rsp_valid=1` with `rsp_ready=0` held 3 cycles while requests pend. `req_ready=0` and `rsp_*` stay stable throughout. Raising `rsp_ready` gives a new accept in that same cycle.
- Drive codes 0..7 via requester 2. The `rsp_out` sequence is 1,1,1,0,1,0,0,0 and the `rsp_parity` sequence is 0,1,1,0,1,0,0,1.
- Assert `rst` while `rsp_valid=1`. The next cycle gives `rsp_valid=0`, `grant_cnt=0`, and `ptr=0`, so requester 0 wins next.
- With `LOGIC_OP_ARB_SWEEP_EN` defined: pulse `sweep_start` with requests pending. `req_ready=0` for 8 cycles, then `sweep_done` pulses once with `sweep_err=0`, then grants resume.
